// File: rtl/softmax_pkg.sv
// Shared constants and types for the softmax divider operand feeder.
//   DATA_W     exp value / divisor width
//   A_W        dividend width (>= DATA_W + FRAC_SHIFT)
//   FRAC_SHIFT left shift applied to each exp value to form the dividend
//   MAX_LEN    frame buffer depth (power of two)
//   DIV_LAT    enabled clocks from operand presentation to divider quotient
package softmax_pkg;

    localparam int DATA_W     = 32;
    localparam int A_W        = 64;
    localparam int FRAC_SHIFT = 32;
    localparam int MAX_LEN    = 64;
    localparam int DIV_LAT    = 63;

    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int ADDR_W  = $clog2(MAX_LEN);
    localparam int FLUSH_W = $clog2(DIV_LAT);

    typedef enum logic [1:0] {
        ACCUM,
        SEND,
        FLUSH
    } state_t;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

endpackage

// File: rtl/softmax_frame_buf.sv
// Frame buffer: simple dual-port RAM, MAX_LEN x DATA_W, synchronous write,
// registered read. The array itself is not reset.
//   clk    clock
//   we     write enable, waddr/wdata write port
//   re     read enable; rdata updates the cycle after raddr is presented
module softmax_frame_buf
    import softmax_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MAX_LEN];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/softmax_div_feeder.sv
// Operand feeder for the 64/32 pipelined softmax divider. Collects a frame of
// exp() values with a saturating sum, then replays each value as
// (exp << FRAC_SHIFT) / sum and flushes the divider, tracking quotient
// valid/last through a tag pipe matched to the divider latency.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data exp value, in_last frame end
//   div_en/div_a/div_b  divider advance, dividend, divisor
//   q_valid/q_last      quotient valid at divider output, last of frame
//   sum_sat/sum_zero/len_trunc  sticky per-frame flags
//   frame_cycles        only with SOFTMAX_FEEDER_PERF_EN: cycles from first
//                       accepted element to q_last of that frame
//
// state | meaning
// ACCUM | accept elements, write buffer, accumulate sum
// SEND  | read buffer in order, present one operand per cycle
// FLUSH | DIV_LAT dummy operands to drain the stalled divider
module softmax_div_feeder
    import softmax_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              div_en,
    output logic [A_W-1:0]    div_a,
    output logic [DATA_W-1:0] div_b,
    output logic              q_valid,
    output logic              q_last,
    output logic              sum_sat,
    output logic              sum_zero,
    output logic              len_trunc
`ifdef SOFTMAX_FEEDER_PERF_EN
    ,
    output logic [31:0]       frame_cycles
`endif
);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [DATA_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]    div_b_q, div_b_d;
    logic                 div_en_q, div_en_d;
    logic                 op_vld_q, op_vld_d;
    logic                 op_last_q, op_last_d;
    logic                 sum_sat_q, sum_sat_d;
    logic                 sum_zero_q, sum_zero_d;
    logic                 len_trunc_q, len_trunc_d;
    tag_t [DIV_LAT-1:0]   tag_pipe_q, tag_pipe_d;

    logic                 accept;
    logic                 first_elem;
    logic [DATA_W-1:0]    sum_base;
    logic [DATA_W:0]      sum_wide;
    logic [DATA_W-1:0]    sum_next;
    logic                 buf_we;
    logic                 buf_re;
    logic [DATA_W-1:0]    rd_data;
    logic [A_W-1:0]       rd_ext;
    tag_t                 tag_in;
    tag_t                 tag_tail;

    softmax_frame_buf u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_cnt_q[ADDR_W-1:0]),
        .wdata (in_data),
        .re    (buf_re),
        .raddr (rd_cnt_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    assign in_ready   = (state_q == ACCUM);
    assign accept     = in_valid & in_ready;
    assign first_elem = (wr_cnt_q == '0);

    // First element of a frame starts from zero so the previous frame's sum
    // never leaks in; a carry out pins the sum at all-ones.
    always_comb begin
        sum_base = first_elem ? '0 : sum_q;
        sum_wide = {1'b0, sum_base} + {1'b0, in_data};
        sum_next = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        flush_cnt_d = flush_cnt_q;
        sum_d       = sum_q;
        div_b_d     = div_b_q;
        div_en_d    = 1'b0;
        op_vld_d    = 1'b0;
        op_last_d   = 1'b0;
        sum_sat_d   = sum_sat_q;
        sum_zero_d  = sum_zero_q;
        len_trunc_d = len_trunc_q;
        buf_we      = 1'b0;
        buf_re      = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    buf_we      = 1'b1;
                    sum_d       = sum_next;
                    sum_sat_d   = (first_elem ? 1'b0 : sum_sat_q) | sum_wide[DATA_W];
                    sum_zero_d  = first_elem ? 1'b0 : sum_zero_q;
                    len_trunc_d = first_elem ? 1'b0 : len_trunc_q;
                    if (in_last || (wr_cnt_q == LEN_W'(MAX_LEN - 1))) begin
                        state_d  = SEND;
                        len_d    = wr_cnt_q + LEN_W'(1);
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        // Divisor is fixed for the whole replay; a zero sum
                        // would divide by zero, so substitute 1.
                        if (sum_next == '0) begin
                            div_b_d    = DATA_W'(1);
                            sum_zero_d = 1'b1;
                        end else begin
                            div_b_d = sum_next;
                        end
                        if (!in_last) begin
                            len_trunc_d = 1'b1;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + LEN_W'(1);
                    end
                end
            end
            SEND: begin
                div_en_d = 1'b1;
                if (rd_cnt_q < len_q) begin
                    // Read issued now, operand presented next cycle.
                    buf_re    = 1'b1;
                    rd_cnt_d  = rd_cnt_q + LEN_W'(1);
                    op_vld_d  = 1'b1;
                    op_last_d = (rd_cnt_q == len_q - LEN_W'(1));
                end else begin
                    state_d     = FLUSH;
                    div_b_d     = DATA_W'(1);
                    flush_cnt_d = FLUSH_W'(DIV_LAT - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ACCUM;
                    div_b_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    div_en_d    = 1'b1;
                    div_b_d     = DATA_W'(1);
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Tags only move when the divider advances, so they stay aligned with the
    // quotient inside the stalled pipeline.
    always_comb begin
        tag_in.vld  = op_vld_q;
        tag_in.last = op_last_q;
        tag_pipe_d  = tag_pipe_q;
        if (div_en_q) begin
            tag_pipe_d = {tag_pipe_q[DIV_LAT-2:0], tag_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            wr_cnt_q    <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            flush_cnt_q <= '0;
            sum_q       <= '0;
            div_b_q     <= '0;
            div_en_q    <= 1'b0;
            op_vld_q    <= 1'b0;
            op_last_q   <= 1'b0;
            sum_sat_q   <= 1'b0;
            sum_zero_q  <= 1'b0;
            len_trunc_q <= 1'b0;
            tag_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            sum_q       <= sum_d;
            div_b_q     <= div_b_d;
            div_en_q    <= div_en_d;
            op_vld_q    <= op_vld_d;
            op_last_q   <= op_last_d;
            sum_sat_q   <= sum_sat_d;
            sum_zero_q  <= sum_zero_d;
            len_trunc_q <= len_trunc_d;
            tag_pipe_q  <= tag_pipe_d;
        end
    end

    // The RAM output register doubles as the dividend register; masking with
    // op_vld_q keeps div_a at zero outside real operand cycles.
    assign rd_ext   = {{(A_W - DATA_W){1'b0}}, rd_data};
    assign div_a    = op_vld_q ? (rd_ext << FRAC_SHIFT) : '0;
    assign div_b    = div_b_q;
    assign div_en   = div_en_q;
    assign tag_tail = tag_pipe_q[DIV_LAT-1];
    assign q_valid  = div_en_q & tag_tail.vld;
    assign q_last   = div_en_q & tag_tail.last;
    assign sum_sat   = sum_sat_q;
    assign sum_zero  = sum_zero_q;
    assign len_trunc = len_trunc_q;

`ifdef SOFTMAX_FEEDER_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] frame_cycles_q, frame_cycles_d;
    logic        perf_run_q, perf_run_d;

    always_comb begin
        perf_cnt_d     = perf_cnt_q;
        perf_run_d     = perf_run_q;
        frame_cycles_d = frame_cycles_q;
        if (accept && first_elem) begin
            perf_cnt_d = 32'd1;
            perf_run_d = 1'b1;
        end else if (perf_run_q && (perf_cnt_q != '1)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
        if (q_last) begin
            frame_cycles_d = perf_cnt_q;
            perf_run_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q     <= '0;
            perf_run_q     <= 1'b0;
            frame_cycles_q <= '0;
        end else begin
            perf_cnt_q     <= perf_cnt_d;
            perf_run_q     <= perf_run_d;
            frame_cycles_q <= frame_cycles_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_softmax_div_feeder.sv
module tb_softmax_div_feeder;

    localparam int LAT = 63;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        div_en;
    logic [63:0] div_a;
    logic [31:0] div_b;
    logic        q_valid;
    logic        q_last;
    logic        sum_sat;
    logic        sum_zero;
    logic        len_trunc;
`ifdef SOFTMAX_FEEDER_PERF_EN
    logic [31:0] frame_cycles;
`endif

    softmax_div_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .div_en    (div_en),
        .div_a     (div_a),
        .div_b     (div_b),
        .q_valid   (q_valid),
        .q_last    (q_last),
        .sum_sat   (sum_sat),
        .sum_zero  (sum_zero),
        .len_trunc (len_trunc)
`ifdef SOFTMAX_FEEDER_PERF_EN
        ,
        .frame_cycles (frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] frame_q[$];
    logic [63:0] en_a[$];
    logic [31:0] en_b[$];
    logic        en_qv[$];
    logic        en_ql[$];
    int          busy;
    int          first_cyc;
    int          qlast_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input bit with_last, input bit hold_valid);
        for (int i = 0; i < frame_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = with_last && (i == frame_q.size() - 1);
            for (int w = 0; w < 200 && !in_ready; w++) step();
            check("in_ready_wait", 64'(in_ready), 64'd1);
            if (i == 0) first_cyc = cyc;
            step();
        end
        if (!hold_valid) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic monitor();
        en_a.delete();
        en_b.delete();
        en_qv.delete();
        en_ql.delete();
        busy      = 0;
        qlast_cyc = -1;
        while (!in_ready && busy < 400) begin
            if (div_en) begin
                en_a.push_back(div_a);
                en_b.push_back(div_b);
                en_qv.push_back(q_valid);
                en_ql.push_back(q_last);
            end
            if (q_last) qlast_cyc = cyc;
            busy++;
            step();
        end
        check("busy_bounded", 64'(in_ready), 64'd1);
    endtask

    task automatic analyse(input string tag, input logic [31:0] exp_b);
        int len;
        int bad_b;
        int bad_fl;
        int bad_qv;
        int bad_ql;
        int n_qv;
        logic [31:0] d;
        len    = frame_q.size();
        bad_b  = 0;
        bad_fl = 0;
        bad_qv = 0;
        bad_ql = 0;
        n_qv   = 0;
        check({tag, "_busy"}, 64'(busy), 64'(len + 64));
        check({tag, "_en_cnt"}, 64'(en_a.size()), 64'(len + LAT));
        for (int i = 0; i < len && i < en_a.size(); i++) begin
            d = frame_q[i];
            check({tag, "_div_a"}, en_a[i], {d, 32'h0});
            if (en_b[i] !== exp_b) bad_b++;
        end
        if (en_b.size() > 0) check({tag, "_div_b"}, 64'(en_b[0]), 64'(exp_b));
        check({tag, "_div_b_bad"}, 64'(bad_b), 64'd0);
        for (int i = len; i < en_a.size(); i++) begin
            if (en_a[i] !== 64'd0 || en_b[i] !== 32'd1) bad_fl++;
        end
        check({tag, "_flush_bad"}, 64'(bad_fl), 64'd0);
        for (int i = 0; i < en_qv.size(); i++) begin
            if (en_qv[i]) n_qv++;
            if (en_qv[i] !== ((i >= LAT) && (i < LAT + len))) bad_qv++;
            if (en_ql[i] !== (i == len + LAT - 1)) bad_ql++;
        end
        check({tag, "_qv_cnt"}, 64'(n_qv), 64'(len));
        check({tag, "_qv_pos"}, 64'(bad_qv), 64'd0);
        check({tag, "_ql_pos"}, 64'(bad_ql), 64'd0);
    endtask

    task automatic check_flags(input string tag, input logic s, input logic z, input logic t);
        check({tag, "_sum_sat"}, 64'(sum_sat), 64'(s));
        check({tag, "_sum_zero"}, 64'(sum_zero), 64'(z));
        check({tag, "_len_trunc"}, 64'(len_trunc), 64'(t));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_div_en"}, 64'(div_en), 64'd0);
        check({tag, "_div_a"}, div_a, 64'd0);
        check({tag, "_div_b"}, 64'(div_b), 64'd0);
        check({tag, "_q_valid"}, 64'(q_valid), 64'd0);
        check({tag, "_q_last"}, 64'(q_last), 64'd0);
        check_flags(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");
`ifdef SOFTMAX_FEEDER_PERF_EN
        check("rst_frame_cycles", 64'(frame_cycles), 64'd0);
`endif
        rst = 1'b0;
        step();

        // {1,1,2}: sum 4
        frame_q = '{32'd1, 32'd1, 32'd2};
        send_frame(1'b1, 1'b0);
        monitor();
        analyse("f112", 32'd4);
        check_flags("f112", 1'b0, 1'b0, 1'b0);
`ifdef SOFTMAX_FEEDER_PERF_EN
        check("perf_vs_bench", 64'(frame_cycles), 64'(qlast_cyc - first_cyc));
        check("perf_69", 64'(frame_cycles), 64'd69);
`endif

        // single element
        frame_q = '{32'h8000_0000};
        send_frame(1'b1, 1'b0);
        monitor();
        analyse("one", 32'h8000_0000);
        check_flags("one", 1'b0, 1'b0, 1'b0);

        // saturating sum
        frame_q = '{32'hFFFF_FFFF, 32'h2};
        send_frame(1'b1, 1'b0);
        monitor();
        analyse("sat", 32'hFFFF_FFFF);
        check_flags("sat", 1'b1, 1'b0, 1'b0);

        // zero sum, also shows sum_sat clearing on a new frame
        frame_q = '{32'h0, 32'h0};
        send_frame(1'b1, 1'b0);
        monitor();
        analyse("zero", 32'd1);
        check_flags("zero", 1'b0, 1'b1, 1'b0);

        // 64 elements with in_last on the 64th: no truncation
        frame_q.delete();
        for (int i = 0; i < 64; i++) frame_q.push_back(32'(i * 3 + 1));
        send_frame(1'b1, 1'b0);
        monitor();
        analyse("full", 32'd6112);
        check_flags("full", 1'b0, 1'b0, 1'b0);

        // 64 elements without in_last, 65th element held off during replay
        frame_q.delete();
        for (int i = 0; i < 64; i++) frame_q.push_back(32'(i + 100));
        send_frame(1'b0, 1'b1);
        in_data = 32'hABC;
        in_last = 1'b1;
        check("trunc_held_ready", 64'(in_ready), 64'd0);
        monitor();
        analyse("trunc", 32'd8416);
        check_flags("trunc", 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("held_accepted_ready", 64'(in_ready), 64'd0);
        frame_q = '{32'hABC};
        monitor();
        analyse("held", 32'hABC);
        check_flags("held", 1'b0, 1'b0, 1'b0);

        // reset during SEND after two operands
        frame_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        send_frame(1'b1, 1'b0);
        step();
        check("mid_op0_en", 64'(div_en), 64'd1);
        check("mid_op0_a", div_a, {32'd10, 32'h0});
        step();
        check("mid_op1_a", div_a, {32'd20, 32'h0});
        check("mid_op1_b", 64'(div_b), 64'd100);
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        step();
        frame_q = '{32'd5};
        send_frame(1'b1, 1'b0);
        monitor();
        analyse("after_rst", 32'd5);
        check_flags("after_rst", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
